jtag_mem_xfer: RTL
==================

JTAG_MEM_XFER -- requirements
Module: jtag_mem_xfer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width and data-register payload width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, abort limit in cycles, used only with JTAG_XFER_TIMEOUT_EN.
REQ-003 SHALL have port clk_i  in  1  single clock (the TAP's TCK); all logic on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  synchronous active-low reset.
REQ-005 SHALL have ports capture_i, shift_i, update_i, sel_i, tdi_i  in  1 each  TAP state strobes, data-register select, serial input.
REQ-006 SHALL have port tdo_o  out  1  serial output, equal to shift-register bit 0.
REQ-007 SHALL have ports addr_i  in  32, wr_i  in  1, inc_i  in  1  base address, write/read select and auto-increment enable from the address register.
REQ-008 SHALL have ports req_o  out  1, we_o  out  1, addr_o  out  32, wdata_o  out  DATA_W  bus request channel.
REQ-009 SHALL have ports gnt_i  in  1, rvalid_i  in  1, rdata_i  in  DATA_W  bus grant and response channel.
REQ-010 SHALL have port busy_o  out  1  high while an access is outstanding.

Function
REQ-011 SHALL hold a shift register SR of DATA_W+2 bits laid out {data, err, ovf}, with ovf at bit 0.
REQ-012 SHALL, while sel_i=1, load SR on capture_i with {rdata_q, err_q, ovf_q}, then clear ovf_q and err_q in the same cycle.
REQ-013 SHALL, while sel_i=1 and shift_i=1, update SR as {tdi_i, SR[W-1:1]}.
REQ-014 SHALL ignore capture_i, shift_i and update_i while sel_i=0.
REQ-015 SHALL run an FSM with states IDLE, REQ, RESP.
REQ-016 SHALL, in IDLE on update_i with sel_i=1, latch we_q=wr_i and wdata_q=SR data field, and enter REQ on the next edge.
REQ-017 SHALL, in REQ, assert req_o=1 with addr_o=ptr_q, we_o=we_q and wdata_o=wdata_q, all stable until gnt_i=1.
REQ-018 SHALL, on gnt_i=1 in REQ, deassert req_o on the next edge and enter RESP.
REQ-019 SHALL, in RESP on rvalid_i=1, store rdata_i into rdata_q when we_q=0, leave rdata_q unchanged when we_q=1, and return to IDLE.
REQ-020 SHALL add 4 to ptr_q, modulo 2^32, on every RESP-to-IDLE transition while inc_i=1; 0xFFFFFFFC wraps to 0x00000000.
REQ-021 SHALL keep base_q; whenever addr_i!=base_q in IDLE, load both ptr_q and base_q with addr_i; this reload takes priority over a start in the same cycle.
REQ-022 SHALL drive busy_o=1 in REQ and RESP and 0 in IDLE.
REQ-023 SHALL, on update_i while busy_o=1, not start an access and set ovf_q=1 (sticky until capture).
REQ-024 SHALL, when capture_i coincides with the RESP-to-IDLE edge, capture the newly arriving rdata_i.

Reset
REQ-025 SHALL, with rst_ni=0 at a clock edge, force state IDLE, SR=0, rdata_q=0, wdata_q=0, ptr_q=0, base_q=0, we_q=0, ovf_q=0, err_q=0, req_o=0 and busy_o=0.
REQ-026 SHALL, on reset mid-access, drop req_o the next cycle and ignore any later gnt_i/rvalid_i for that access.

Configuration
REQ-027 SHALL implement a timeout when JTAG_XFER_TIMEOUT_EN is defined: a counter clears on entry to REQ; after TIMEOUT_CYC consecutive cycles in REQ or RESP, force IDLE, set err_q=1, drop req_o and leave ptr_q unchanged.
REQ-028 SHALL, without JTAG_XFER_TIMEOUT_EN, have no counter, keep err_q constant 0, and wait indefinitely.

Structure
REQ-029 SHALL place the FSM state enum, the SR field offsets and the TIMEOUT_CYC default in package jtag_xfer_pkg.
REQ-030 SHALL be a single module with no sub-modules; the timeout counter is inline logic under the macro.

Verification
REQ-031 SHALL cover a write: addr_i=0x80000000, wr_i=1, shift in data 0xDEADBEEF, pulse update -> one req_o with addr_o=0x80000000, wdata_o=0xDEADBEEF, we_o=1.
REQ-032 SHALL cover a read: wr_i=0, update, then rdata_i=0x12345678 with rvalid -> next capture shifts out 0x12345678, err=0, ovf=0.
REQ-033 SHALL cover auto-increment: inc_i=1, base 0xFFFFFFF8, three reads -> addr_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-034 SHALL cover overrun: gnt_i held 0, second update -> no second request, captured ovf=1, and the following capture shows ovf=0.
REQ-035 SHALL cover timeout: with macro defined, gnt_i=0 for TIMEOUT_CYC cycles -> req_o falls, busy_o=0, captured err=1.
REQ-036 SHALL cover reset mid-access: rst_ni=0 in RESP, later rvalid_i=1 -> rdata_q stays 0, state IDLE.

Source files
------------

// File: rtl/jtag_xfer_pkg.sv
// Shared definitions for the JTAG memory-transfer data register: FSM states,
// shift-register field offsets and the default timeout limit.
package jtag_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } xfer_state_e;

  // Shift register layout is {data, err, ovf} with ovf in bit 0
  localparam int SR_OVF_BIT  = 0;
  localparam int SR_ERR_BIT  = 1;
  localparam int SR_DATA_LSB = 2;

  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/jtag_mem_xfer.sv
// JTAG data register that turns each update into one bus access with optional
// address auto-increment. Define JTAG_XFER_TIMEOUT_EN to abort stalled accesses.
module jtag_mem_xfer
  import jtag_xfer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              sel_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  input  logic [31:0]       addr_i,
  input  logic              wr_i,
  input  logic              inc_i,
  output logic              req_o,
  output logic              we_o,
  output logic [31:0]       addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o
);

  localparam int SR_W = DATA_W + SR_DATA_LSB;

  xfer_state_e       state_q;
  logic [SR_W-1:0]   sr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       ptr_q;
  logic [31:0]       base_q;
  logic              we_q;
  logic              ovf_q;
  logic              err_q;
  logic              req_q;
  logic              busy_q;

  logic              cap_en;
  logic              shift_en;
  logic              upd_en;
  logic              reload;
  logic              tmo_hit;
  logic              resp_done;
  logic [DATA_W-1:0] cap_data;

  assign cap_en    = sel_i & capture_i;
  assign shift_en  = sel_i & shift_i;
  assign upd_en    = sel_i & update_i;
  assign reload    = (state_q == IDLE) && (addr_i != base_q);
  assign resp_done = (state_q == RESP) && rvalid_i && !tmo_hit;

  // A capture on the completing edge must see the read data arriving now
  assign cap_data  = (resp_done && !we_q) ? rdata_i : rdata_q;

  // A non-positive TIMEOUT_CYC leaves this empty marker block in the hierarchy
  if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_invalid
  end

`ifdef JTAG_XFER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        tmo_cnt_q <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end else if (cap_en) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (cap_en) begin
        sr_q <= {cap_data, err_q, ovf_q};
      end else if (shift_en) begin
        sr_q <= {tdi_i, sr_q[SR_W-1:1]};
      end

      // Overrun flag is sticky; a coinciding set wins over the capture clear
      if (upd_en && busy_q) begin
        ovf_q <= 1'b1;
      end else if (cap_en) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (reload) begin
            ptr_q  <= addr_i;
            base_q <= addr_i;
          end else if (upd_en) begin
            we_q    <= wr_i;
            wdata_q <= sr_q[SR_W-1:SR_DATA_LSB];
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (gnt_i) begin
            req_q   <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (tmo_hit) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (rvalid_i) begin
            if (!we_q) begin
              rdata_q <= rdata_i;
            end
            if (inc_i) begin
              ptr_q <= ptr_q + 32'd4;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tdo_o   = sr_q[SR_OVF_BIT];
  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = ptr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = busy_q;

endmodule
